// File: rtl/rvv_pkg.sv
// rtl/rvv_pkg.sv - shared opcodes, issue classes and instruction field positions
package rvv_pkg;

  localparam logic [6:0] OPC_OPV     = 7'h57;
  localparam logic [6:0] OPC_LOADFP  = 7'h07;
  localparam logic [6:0] OPC_STOREFP = 7'h27;

  // funct3 value that marks an OP-V configuration instruction (vset*)
  localparam logic [2:0] F3_CFG = 3'd7;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2,
    CLS_CFG   = 2'd3
  } issue_class_e;

  // Instruction field positions
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int VD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int VS1_LSB = 15;
  localparam int VS2_LSB = 20;
  localparam int VM_BIT  = 25;
  localparam int MOP_LSB = 26;
  localparam int MOP_MSB = 27;

endpackage

// File: rtl/rvv_scoreboard.sv
// rtl/rvv_scoreboard.sv - pending-write scoreboard with four source and one destination query
module rvv_scoreboard
  import rvv_pkg::*;
#(
  parameter int NUM_VEC    = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_VEC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [3:0]            src_en,
  input  logic [ADDR_WIDTH-1:0] src_addr0,
  input  logic [ADDR_WIDTH-1:0] src_addr1,
  input  logic [ADDR_WIDTH-1:0] src_addr2,
  input  logic [ADDR_WIDTH-1:0] src_addr3,
  input  logic                  dst_en,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  output logic                  hazard,
  output logic                  busy
);

  logic [NUM_VEC-1:0] pending;
  logic [NUM_VEC-1:0] set_mask;
  logic [NUM_VEC-1:0] clr_mask;

  // One-hot masks for the register being claimed and the one retiring
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  // Pending bits: a retiring write clears, a newly accepted writer sets
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | set_mask;
  end

  // Any queried register still waiting on a write blocks acceptance
  always_comb begin
    hazard = (src_en[0] & pending[src_addr0]) |
             (src_en[1] & pending[src_addr1]) |
             (src_en[2] & pending[src_addr2]) |
             (src_en[3] & pending[src_addr3]) |
             (dst_en    & pending[dst_addr]);
  end

  assign busy = |pending;

endmodule

// File: rtl/rvv_issue_ctrl.sv
// rtl/rvv_issue_ctrl.sv - vector issue control: decode, RAW/WAW stall, operand read and writeback timing
module rvv_issue_ctrl
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int NUM_VEC    = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_VEC),
  parameter int INSN_WIDTH = 32,
  parameter int WB_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  insn_valid,
  input  logic [INSN_WIDTH-1:0] insn_in,
  output logic                  insn_ready,
  output logic [3:0]            rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr0,
  output logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [ADDR_WIDTH-1:0] rd_addr3,
  output logic                  issue_valid,
  output logic [1:0]            issue_class,
  output logic                  wb_en,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  illegal_insn,
  output logic                  idle
);

  // Vector length only matters to the datapath; kept here for a uniform parameter set
  localparam int unused_vlen = VLEN;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [1:0]            mop;
  logic                  vm;
  logic                  is_opv, is_load, is_store, is_cfg, legal;
  logic [3:0]            src_need;
  logic                  has_vd;
  logic [ADDR_WIDTH-1:0] vs1, vs2, vs3, vd;
  issue_class_e          cls;
  logic                  hazard, sb_busy, accept;
  logic [WB_LAT:0]       wb_vld;
  logic [ADDR_WIDTH-1:0] wb_pipe [WB_LAT+1];
  logic                  unused_bits;

  assign opcode = insn_in[OPC_MSB:OPC_LSB];
  assign funct3 = insn_in[F3_MSB:F3_LSB];
  assign mop    = insn_in[MOP_MSB:MOP_LSB];
  assign vm     = insn_in[VM_BIT];
  assign vs1    = insn_in[VS1_LSB +: ADDR_WIDTH];
  assign vs2    = insn_in[VS2_LSB +: ADDR_WIDTH];
  assign vs3    = insn_in[VD_LSB +: ADDR_WIDTH];
  assign vd     = insn_in[VD_LSB +: ADDR_WIDTH];
  assign unused_bits = ^insn_in[INSN_WIDTH-1:MOP_MSB+1];

  assign is_opv   = (opcode == OPC_OPV);
  assign is_load  = (opcode == OPC_LOADFP);
  assign is_store = (opcode == OPC_STOREFP);
  assign is_cfg   = is_opv && (funct3 == F3_CFG);
  assign legal    = is_opv || is_load || is_store;
  assign has_vd   = (is_opv && !is_cfg) || is_load;

  // Operand ports: 0 vs1, 1 vs2, 2 vs3 (store data), 3 mask v0
  always_comb begin
    src_need    = 4'b0000;
    src_need[0] = is_opv && (funct3 <= 3'd2);
    src_need[1] = (is_opv && !is_cfg) || ((is_load || is_store) && mop[0]);
    src_need[2] = is_store;
    src_need[3] = legal && !is_cfg && !vm;
  end

  // Issue class of the decoded instruction
  always_comb begin
    cls = CLS_ALU;
    if (is_load)       cls = CLS_LOAD;
    else if (is_store) cls = CLS_STORE;
    else if (is_cfg)   cls = CLS_CFG;
  end

  rvv_scoreboard #(
    .NUM_VEC   (NUM_VEC),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && has_vd),
    .set_addr (vd),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .src_en   (src_need),
    .src_addr0(vs1),
    .src_addr1(vs2),
    .src_addr2(vs3),
    .src_addr3('0),
    .dst_en   (has_vd),
    .dst_addr (vd),
    .hazard   (hazard),
    .busy     (sb_busy)
  );

  assign insn_ready = !rst && !hazard;
  assign accept     = insn_valid && insn_ready;

  // Issue stage: one-cycle strobes, read addresses hold until a port is next used
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid  <= 1'b0;
      illegal_insn <= 1'b0;
      issue_class  <= CLS_ALU;
      rd_en        <= 4'b0000;
      rd_addr0     <= '0;
      rd_addr1     <= '0;
      rd_addr2     <= '0;
      rd_addr3     <= '0;
    end else begin
      issue_valid  <= accept && legal;
      illegal_insn <= accept && !legal;
      rd_en        <= accept ? src_need : 4'b0000;
      if (accept && legal)       issue_class <= cls;
      if (accept && src_need[0]) rd_addr0 <= vs1;
      if (accept && src_need[1]) rd_addr1 <= vs2;
      if (accept && src_need[2]) rd_addr2 <= vs3;
      if (accept && src_need[3]) rd_addr3 <= '0;
    end
  end

  // Writeback delay line: stage k holds a writer accepted k+1 cycles ago
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld <= '0;
      for (int i = 0; i <= WB_LAT; i++) wb_pipe[i] <= '0;
    end else begin
      wb_vld[0]  <= accept && has_vd;
      wb_pipe[0] <= vd;
      for (int i = 1; i <= WB_LAT; i++) begin
        wb_vld[i]  <= wb_vld[i-1];
        wb_pipe[i] <= wb_pipe[i-1];
      end
    end
  end

  assign wb_en   = wb_vld[WB_LAT];
  assign wb_addr = wb_pipe[WB_LAT];
  assign idle    = !sb_busy && !issue_valid && !(|wb_vld);

endmodule

// File: doc/rvv_issue_ctrl.md
RVV_ISSUE_CTRL -- requirements
Module: rvv_issue_ctrl

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector length in bits (passed through to the package; no datapath here).
REQ-002 SHALL have parameter NUM_VEC, default 32, number of vector registers; ADDR_WIDTH = clog2(NUM_VEC).
REQ-003 SHALL have parameter INSN_WIDTH, default 32, instruction width.
REQ-004 SHALL have parameter WB_LAT, default 2 (legal range 1..8), cycles from issue to writeback for ALU and load.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port insn_valid, input, 1, instruction offered.
REQ-008 SHALL have port insn_in, input, INSN_WIDTH, the instruction.
REQ-009 SHALL have port insn_ready, output, 1, instruction accepted this cycle when high with insn_valid.
REQ-010 SHALL have ports rd_en, output, 4, and rd_addr0..rd_addr3, output, ADDR_WIDTH each; ports 0..3 carry vs1, vs2, vs3, and mask v0.
REQ-011 SHALL have ports issue_valid, output, 1, and issue_class, output, 2 (0 ALU, 1 LOAD, 2 STORE, 3 CFG).
REQ-012 SHALL have ports wb_en, output, 1, and wb_addr, output, ADDR_WIDTH, vector writeback strobe.
REQ-013 SHALL have ports illegal_insn, output, 1 (one-cycle pulse), and idle, output, 1.

Function
REQ-014 SHALL decode OP-V (0x57), LOAD-FP (0x07) and STORE-FP (0x27); funct3 = insn[14:12], mop = insn[27:26], vm = insn[25].
REQ-015 SHALL flag any other opcode as illegal: it is accepted, illegal_insn pulses in cycle T+1, and there is no read, issue or writeback.
REQ-016 SHALL require vs1 for OP-V with funct3 in {0,1,2} only.
REQ-017 SHALL require vs2 for OP-V with funct3 != 7, and for LOAD/STORE with mop[0] = 1.
REQ-018 SHALL require vs3 (insn[11:7]) for STORE always.
REQ-019 SHALL require v0 for any non-CFG instruction with vm = 0.
REQ-020 SHALL treat the destination as vd for OP-V with funct3 != 7 and for LOAD; STORE and CFG (funct3 = 7) write no vector register.
REQ-021 SHALL keep a NUM_VEC-bit pending scoreboard.
REQ-022 SHALL drive insn_ready = 0 when any required source or the destination has its pending bit set (RAW/WAW stall); otherwise insn_ready = 1.
REQ-023 SHALL apply the following timing for acceptance in cycle T:
- rd_en bits for required sources, rd_addr*, issue_valid and issue_class are asserted in T+1 only;
- rd_en is 0 for unused ports;
- rd_addr* hold their last value when unused.
REQ-024 SHALL set pending[vd] at the clock edge ending cycle T, so that it is visible from T+1.
REQ-025 SHALL assert wb_en with wb_addr = vd in cycle T+1+WB_LAT, and clear pending[vd] at the edge ending that cycle (no bypass; a dependent instruction is accepted at T+2+WB_LAT at the earliest).
REQ-026 SHALL keep the writeback delay line fully pipelined: one accepted writer per cycle with no stalls when there are no hazards.
REQ-027 SHALL drive idle = 1 when there are no pending bits and no valid entry in the issue or writeback pipeline.
REQ-028 SHALL not modify the scoreboard when insn_valid = 0 or insn_ready = 0.

Reset
REQ-029 SHALL, while rst = 1 at a clock edge, clear pending, all pipeline valids, rd_en, issue_valid, wb_en and illegal_insn to 0, and set issue_class, wb_addr and rd_addr* to 0.
REQ-030 SHALL, while rst = 1, hold insn_ready = 0; idle reads 1 from the first cycle after reset.
REQ-031 SHALL discard in-flight instructions on reset mid-operation, with no wb_en after reset deasserts.

Structure
REQ-032 SHALL place opcode constants (0x57, 0x07, 0x27), the issue_class enum and the field-slice helper localparams in a shared package rvv_pkg.
REQ-033 SHALL implement the scoreboard as sub-module rvv_scoreboard, with set port, clear port, and query of 4 sources plus 1 destination.

Verification
REQ-034 SHALL cover a single instruction: 0x022081D7 (vadd.vv v3,v1,v2) at T=0 -> T1: rd_en=0011, rd_addr0=1, rd_addr1=2, issue_class=0; T3 (WB_LAT=2): wb_en=1, wb_addr=3.
REQ-035 SHALL cover a RAW stall: 0x022081D7 then 0x02318257 (v4 <- v3,v3) -> insn_ready=0 in cycles 1..3; second instruction accepted in cycle 4, wb_addr=4 in cycle 7.
REQ-036 SHALL cover back-to-back independent instructions v3<-v1,v2 then v5<-v1,v2 -> accepted in cycles 0 and 1, wb_en in cycles 3 and 4.
REQ-037 SHALL cover a masked store with indexed mop (vm=0, mop=01, vs3=6, vs2=7) -> rd_en=1110, addresses 7/6/0, issue_class=2, no wb_en.
REQ-038 SHALL cover an illegal opcode 0x0000000B -> accepted, illegal_insn=1 in cycle 1, no issue_valid, idle stays 1.
REQ-039 SHALL cover reset mid-operation: rst=1 in cycle 1 after a writer was accepted -> no wb_en, pending=0, idle=1.
